// File: rtl/fifo_word_packer.sv
// Drains a registered-read FIFO and packs PACK words per wide output beat,
// with a flush request that emits a tagged partial beat.
module fifo_word_packer #(
   parameter int DWIDTH = 16,
   parameter int PACK   = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   input  logic [DWIDTH-1:0]        fifo_dout,
   input  logic                     flush,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DWIDTH*PACK-1:0]   m_data,
   output logic [$clog2(PACK):0]    m_count,
   output logic                     m_last,
   output logic                     busy
);

   localparam int              CW     = $clog2(PACK) + 1;
   localparam logic [CW-1:0]   PACK_C = CW'(PACK);

   logic [DWIDTH-1:0]       lanes [PACK];
   logic [CW-1:0]           fill;
   logic                    inflight;
   logic                    flush_pending;
   logic                    run;
   logic                    out_free;
   logic                    load_full;
   logic                    flush_resolve;
   logic                    emit;
   logic [DWIDTH*PACK-1:0]  packed_lanes;

   // run holds reads off for one cycle after reset release.
   assign out_free      = !m_valid || m_ready;
   assign fifo_rd_en    = run && !fifo_empty && !flush_pending &&
                          ((fill + CW'(inflight)) < PACK_C);
   assign load_full     = (fill == PACK_C) && !flush_pending && out_free;
   assign flush_resolve = flush_pending && !inflight && out_free;
   assign emit          = load_full || (flush_resolve && (fill != '0));
   assign busy          = (fill != '0) || inflight || flush_pending || m_valid;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      packed_lanes = '0;
      for (int i = 0; i < PACK; i++) begin
         if (CW'(i) < fill) packed_lanes[i*DWIDTH +: DWIDTH] = lanes[i];
      end
   end

   // NOTE: lane storage has no reset; fill gates what is ever presented downstream.
   always_ff @(posedge clk) begin
      if (inflight) begin
         for (int i = 0; i < PACK; i++) begin
            if (CW'(i) == fill) lanes[i] <= fifo_dout;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run           <= 1'b0;
         fill          <= '0;
         inflight      <= 1'b0;
         flush_pending <= 1'b0;
         m_valid       <= 1'b0;
         m_data        <= '0;
         m_count       <= '0;
         m_last        <= 1'b0;
      end else begin
         run      <= 1'b1;
         inflight <= fifo_rd_en;

         if (emit)          fill <= '0;
         else if (inflight) fill <= fill + CW'(1);

         // A flush arriving while one is pending is ignored.
         if (flush_resolve) flush_pending <= 1'b0;
         else if (flush)    flush_pending <= 1'b1;

         if (emit) begin
            m_valid <= 1'b1;
            m_data  <= packed_lanes;
            m_count <= fill;
            m_last  <= flush_resolve;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a registered-read FIFO model
// and a negedge beat monitor.
module tb_fifo_word_packer;

   localparam int DWIDTH = 16;
   localparam int PACK   = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [15:0]   fifo_dout = '0;
   logic          flush = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [63:0]   m_data;
   logic [2:0]    m_count;
   logic          m_last;
   logic          busy;

   fifo_word_packer #(.DWIDTH(DWIDTH), .PACK(PACK)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_count    (m_count),
      .m_last     (m_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: the stimulus owns the write pointer, the model owns the read side.
   logic [15:0] mem [256];
   int          wptr = 0;
   int          rptr = 0;
   logic        fifo_clr = 1'b0;

   assign fifo_empty = (rptr == wptr);

   always @(posedge clk) begin
      if (fifo_clr) rptr <= wptr;
      else if (fifo_rd_en) begin
         fifo_dout <= mem[rptr];
         rptr      <= rptr + 1;
      end
   end

   int          nrd = 0;
   int          nb  = 0;
   logic [63:0] bd [64];
   logic [2:0]  bc [64];
   logic        bl [64];

   always @(negedge clk) begin
      if (rstn) begin
         if (fifo_rd_en) nrd++;
         if (m_valid && m_ready && nb < 64) begin
            bd[nb] = m_data;
            bc[nb] = m_count;
            bl[nb] = m_last;
            nb++;
         end
      end
   end

   int n_err = 0;
   int n_chk = 0;
   int r0;
   int b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      mem[wptr] = w;
      wptr++;
   endtask

   initial begin
      // Reset with a preloaded FIFO.
      for (int i = 1; i <= 8; i++) push(16'(16'h0011 * i));
      tick(3);
      check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_data", m_data, 64'd0);
      check("rst_count", 64'(m_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      m_ready = 1'b1;
      rstn = 1'b1;
      #1;
      check("rel_rd_en_first_cycle", 64'(fifo_rd_en), 64'd0);
      tick(1);
      check("rel_rd_en_next_cycle", 64'(fifo_rd_en), 64'd1);
      tick(20);
      check("pre_beats", 64'(nb), 64'd2);
      check("pre_beat0", bd[0], 64'h0044_0033_0022_0011);
      check("pre_beat1", bd[1], 64'h0088_0077_0066_0055);
      check("pre_idle", 64'(busy), 64'd0);

      // Basic pack with latency check.
      r0 = nrd; b0 = nb;
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      tick(5);
      check("pack_not_yet", 64'(m_valid), 64'd0);
      tick(1);
      check("pack_valid", 64'(m_valid), 64'd1);
      check("pack_data", m_data, 64'h4444_3333_2222_1111);
      check("pack_count", 64'(m_count), 64'd4);
      check("pack_last", 64'(m_last), 64'd0);
      tick(2);
      check("pack_reads", 64'(nrd - r0), 64'd4);
      check("pack_beats", 64'(nb - b0), 64'd1);

      // Backpressure: eight reads then stall, beat held.
      m_ready = 1'b0;
      r0 = nrd; b0 = nb;
      for (int i = 1; i <= 12; i++) push(16'(i));
      tick(10);
      check("bp_data_t10", m_data, 64'h0004_0003_0002_0001);
      tick(10);
      check("bp_reads", 64'(nrd - r0), 64'd8);
      check("bp_rd_en_stalled", 64'(fifo_rd_en), 64'd0);
      check("bp_valid", 64'(m_valid), 64'd1);
      check("bp_data_t20", m_data, 64'h0004_0003_0002_0001);
      check("bp_count", 64'(m_count), 64'd4);
      m_ready = 1'b1;
      tick(25);
      check("bp_beats", 64'(nb - b0), 64'd3);
      check("bp_beat0", bd[b0], 64'h0004_0003_0002_0001);
      check("bp_beat1", bd[b0+1], 64'h0008_0007_0006_0005);
      check("bp_beat2", bd[b0+2], 64'h000C_000B_000A_0009);
      check("bp_beat2_count", 64'(bc[b0+2]), 64'd4);
      check("bp_beat2_last", 64'(bl[b0+2]), 64'd0);

      // Partial flush of three words.
      m_ready = 1'b0;
      b0 = nb;
      push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
      tick(6);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(3);
      check("pf_valid", 64'(m_valid), 64'd1);
      check("pf_data", m_data, 64'h0000_CCCC_BBBB_AAAA);
      check("pf_count", 64'(m_count), 64'd3);
      check("pf_last", 64'(m_last), 64'd1);
      m_ready = 1'b1;
      check("pf_busy_at_accept", 64'(busy), 64'd1);
      tick(1);
      check("pf_busy_after", 64'(busy), 64'd0);
      check("pf_valid_after", 64'(m_valid), 64'd0);
      check("pf_beats", 64'(nb - b0), 64'd1);

      // Flush with nothing assembled.
      b0 = nb;
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("ef_pending", 64'(busy), 64'd1);
      tick(1);
      check("ef_cleared", 64'(busy), 64'd0);
      check("ef_no_valid", 64'(m_valid), 64'd0);
      tick(2);
      check("ef_no_beat", 64'(nb - b0), 64'd0);

      // Flush coincident with the second read.
      b0 = nb;
      push(16'h1234); push(16'h5678); push(16'h9ABC);
      push(16'hDEF0); push(16'h1357); push(16'h2468);
      tick(1);
      check("fr_second_rd", 64'(fifo_rd_en), 64'd1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("fr_reads_blocked", 64'(fifo_rd_en), 64'd0);
      tick(2);
      check("fr_valid", 64'(m_valid), 64'd1);
      check("fr_data", m_data, 64'h0000_0000_5678_1234);
      check("fr_count", 64'(m_count), 64'd2);
      check("fr_last", 64'(m_last), 64'd1);
      tick(3);
      check("fr_third_rd", 64'(fifo_rd_en), 64'd1);

      // Reset with fill = 2 and a read in flight.
      rstn = 1'b0;
      fifo_clr = 1'b1;
      #1;
      check("mr_rd_en", 64'(fifo_rd_en), 64'd0);
      check("mr_valid", 64'(m_valid), 64'd0);
      check("mr_data", m_data, 64'd0);
      check("mr_count", 64'(m_count), 64'd0);
      check("mr_last", 64'(m_last), 64'd0);
      check("mr_busy", 64'(busy), 64'd0);
      tick(1);
      fifo_clr = 1'b0;
      tick(1);
      rstn = 1'b1;
      b0 = nb;
      push(16'h0A0A); push(16'h0B0B); push(16'h0C0C); push(16'h0D0D);
      #1;
      check("mr_rel_rd_en", 64'(fifo_rd_en), 64'd0);
      tick(7);
      check("mr_valid_new", 64'(m_valid), 64'd1);
      check("mr_data_new", m_data, 64'h0D0D_0C0C_0B0B_0A0A);
      check("mr_count_new", 64'(m_count), 64'd4);
      check("mr_last_new", 64'(m_last), 64'd0);
      tick(2);
      check("mr_beats", 64'(nb - b0), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the 16-bit synchronous FIFO.
- Drains the FIFO through its rd_en/dout/empty interface and absorbs the FIFO's one-cycle registered read latency.
- Packs PACK consecutive words into one wide word and presents it on a valid/ready master stream.
- A flush request emits a final partial word tagged with a word count and a last flag.

Parameters:
- DWIDTH, 16, width of one FIFO word; must equal the upstream FIFO DWIDTH.
- PACK, 4, FIFO words per output beat; integer >= 2.

Ports:
- clk  input  1  rising-edge clock, shared with the FIFO
- rstn  input  1  reset; one clock, asynchronous, active-low
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  FIFO read enable
- fifo_dout  input  DWIDTH  FIFO data; valid in the cycle after a rd_en cycle
- flush  input  1  single-cycle pulse requesting emission of the partial word
- m_valid  output  1  output beat valid
- m_ready  input  1  downstream accept
- m_data  output  DWIDTH*PACK  packed beat; lane 0 (LSBs) holds the oldest word
- m_count  output  $clog2(PACK)+1  number of valid lanes in the beat (1..PACK)
- m_last  output  1  beat was produced by a flush
- busy  output  1  high when fill != 0, inflight = 1, flush_pending = 1, or m_valid = 1

Behaviour:
- Reset (async, rstn low):
  - fill = 0, inflight = 0, flush_pending = 0.
  - m_valid = 0, m_data = 0, m_count = 0, m_last = 0, fifo_rd_en = 0.
  - A word in flight at reset is dropped; the FIFO shares rstn.
- State:
  - Assembly register of PACK lanes.
  - fill counter, 0..PACK.
  - inflight bit: set the cycle after fifo_rd_en is high, meaning fifo_dout is valid in that cycle.
  - flush_pending bit.
  - One output register holding m_data, m_count and m_last.
- Read issue (combinational): fifo_rd_en = !fifo_empty && !flush_pending && (fill + inflight < PACK).
  - The block never reads an empty FIFO.
  - The block never over-commits assembly lanes.
- Capture: when inflight = 1, fifo_dout is written to lane[fill] and fill increments at the clock edge. inflight then takes the value of fifo_rd_en from the same cycle.
- Full transfer:
  - Condition: registered fill == PACK and the output register is free (m_valid = 0, or m_valid && m_ready this cycle).
  - At the edge: m_data = lanes, m_count = PACK, m_last = 0, m_valid = 1, fill = 0.
  - While fill == PACK no reads are issued.
- Latency and throughput (PACK = 4, FIFO never empty, m_ready = 1):
  - rd_en is high in cycles 0-3; captures happen at the ends of cycles 1-4.
  - Transfer happens at the end of cycle 5; m_valid = 1 in cycle 6.
  - Steady-state throughput is PACK words per PACK+2 cycles.
- Output handshake:
  - A beat completes when m_valid && m_ready.
  - m_data, m_count and m_last are held stable while m_valid && !m_ready.
  - m_valid drops after acceptance unless a new transfer loads in the same cycle; that back-to-back load is allowed.
  - m_data keeps its last value when idle.
- Flush:
  - A flush pulse sets flush_pending and blocks new reads.
  - flush while flush_pending = 1 is ignored.
  - Once inflight = 0 and the output register is free, the flush resolves:
    - fill > 0: emit lanes with m_count = fill and m_last = 1; unused upper lanes are driven 0. Then fill = 0 and flush_pending = 0.
    - fill == PACK: emit the beat with m_count = PACK and m_last = 1.
    - fill == 0: flush_pending clears and no beat is emitted.
  - flush in the same cycle as rd_en: that read still completes and is included in the flush beat.
- Simultaneous events:
  - A capture and an output acceptance in the same cycle are independent.
  - A transfer takes priority over a capture only in the sense that fill == PACK already blocks captures, since nothing can be in flight then.
- Width rules:
  - fill and m_count are $clog2(PACK)+1 bits.
  - Comparisons against PACK are unsigned; no wrap.

Test Plan:
- Reset: FIFO preloaded with 8 words, hold rstn low -> fifo_rd_en = 0, m_valid = 0, m_data = 0. Release rstn -> first rd_en one cycle later.
- Pack: FIFO holds 0x1111, 0x2222, 0x3333, 0x4444, m_ready = 1 -> one beat with m_data = 0x4444_3333_2222_1111, m_count = 4, m_last = 0, m_valid first high 6 cycles after first rd_en. Exactly 4 rd_en pulses.
- Backpressure: 12 words written, m_ready = 0 for 20 cycles -> first beat held stable, fifo_rd_en stops after 8 reads (4 in the output register, 4 in assembly). Then m_ready = 1 -> 3 beats 0x0004_0003_0002_0001, 0x0008_0007_0006_0005, 0x000C_000B_000A_0009 in order, none lost.
- Partial flush: 3 words 0xAAAA, 0xBBBB, 0xCCCC, then flush -> beat m_data = 0x0000_CCCC_BBBB_AAAA, m_count = 3, m_last = 1. busy falls the cycle after acceptance.
- Empty flush and flush-during-read: flush with fill = 0 -> no beat, flush_pending clears next cycle. flush coincident with the 2nd rd_en -> beat with m_count = 2, m_last = 1.
- Reset mid-operation: assert rstn while fill = 2 and inflight = 1 -> all outputs return to reset values immediately. After release, new words pack from lane 0 with no stale data.
